// File: rtl/instr_pkg.sv
// Shared RV32I encoder definitions: one-hot instruction-type codes, base opcodes,
// the decoded-field bundle and the type/opcode legality helpers.
package instr_pkg;

    localparam logic [5:0] TYPE_R = 6'b100000;
    localparam logic [5:0] TYPE_I = 6'b010000;
    localparam logic [5:0] TYPE_S = 6'b001000;
    localparam logic [5:0] TYPE_B = 6'b000100;
    localparam logic [5:0] TYPE_U = 6'b000010;
    localparam logic [5:0] TYPE_J = 6'b000001;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    typedef struct packed {
        logic [5:0]  itype;
        logic [6:0]  opcode;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [4:0]  rdt;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [19:0] imm;
    } instr_fields_t;

    function automatic logic onehot6(input logic [5:0] t);
        return (t != 6'd0) && ((t & (t - 6'd1)) == 6'd0);
    endfunction

    function automatic logic opcode_matches(input logic [5:0] t, input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (t)
            TYPE_R:  ok = (op == OP_R);
            TYPE_I:  ok = (op == OP_JALR) || (op == OP_LOAD) || (op == OP_IMM);
            TYPE_S:  ok = (op == OP_STORE);
            TYPE_B:  ok = (op == OP_BR);
            TYPE_U:  ok = (op == OP_LUI) || (op == OP_AUIPC);
            TYPE_J:  ok = (op == OP_JAL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input, encoded-word output and address-control signals of instr_encoder.
// master = producer/consumer side, slave = the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_type;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rs0;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rdt;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [19:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_base;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_type, in_opcode, in_rs0, in_rs1, in_rdt,
               in_funct3, in_funct7, in_imm, addr_load, addr_base, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rs0, in_rs1, in_rdt,
               in_funct3, in_funct7, in_imm, addr_load, addr_base, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x WIDTH FIFO (DEPTH a power of two). Push is refused when full
// even if a pop happens in the same cycle; the read port shows the head combinationally.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // count never exceeds DEPTH = 2**AW, so its MSB alone flags full
    assign full  = count[AW];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I field bundles into 32-bit words, queues them and emits them with
// a word address. Build option OPCODE_CHECK_EN also drops bundles whose opcode mismatches the type.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    instr_fields_t     fields;
    logic              type_ok;
    logic              op_ok;
    logic              bundle_ok;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic              full;
    logic              empty;
    logic [31:0]       enc_word;
    logic [31:0]       head_word;
    logic [31:0]       hold_q;
    logic              err_p1;
    logic [7:0]        err_cnt_q;
    logic [ADDR_W-1:0] addr_q;

    // Immediate placement mirrors the decoder so encode-then-decode is lossless
    function automatic logic [31:0] encode(input instr_fields_t f);
        logic [31:0] w;
        w = {25'd0, f.opcode};
        case (f.itype)
            TYPE_R: w = {f.funct7, f.rs1, f.rs0, f.funct3, f.rdt, f.opcode};
            TYPE_I: w = {f.imm[11:0], f.rs0, f.funct3, f.rdt, f.opcode};
            TYPE_S: w = {f.imm[11:5], f.rs1, f.rs0, f.funct3, f.imm[4:0], f.opcode};
            TYPE_B: w = {f.imm[11], f.imm[9:4], f.rs1, f.rs0, f.funct3,
                         f.imm[3:0], f.imm[10], f.opcode};
            TYPE_U: w = {f.imm[19:0], f.rdt, f.opcode};
            TYPE_J: w = {f.imm[19], f.imm[9:0], f.imm[10], f.imm[18:11], f.rdt, f.opcode};
            default: w = {25'd0, f.opcode};
        endcase
        return w;
    endfunction

    always_comb begin
        fields        = '0;
        fields.itype  = bus.in_type;
        fields.opcode = bus.in_opcode;
        fields.rs0    = bus.in_rs0;
        fields.rs1    = bus.in_rs1;
        fields.rdt    = bus.in_rdt;
        fields.funct3 = bus.in_funct3;
        fields.funct7 = bus.in_funct7;
        fields.imm    = bus.in_imm;
    end

    assign type_ok = onehot6(fields.itype);
`ifdef OPCODE_CHECK_EN
    assign op_ok = opcode_matches(fields.itype, fields.opcode);
`else
    assign op_ok = 1'b1;
`endif
    assign bundle_ok = type_ok && op_ok;
    assign enc_word  = encode(fields);

    // Malformed bundles are still accepted (consumed) so upstream never stalls on them
    assign accept = bus.in_valid && !full;
    assign push   = accept && bundle_ok;
    assign drop   = accept && !bundle_ok;
    assign pop    = !empty && bus.out_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enc_word),
        .pop   (pop),
        .dout  (head_word),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? hold_q : head_word;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_p1;
    assign bus.err_cnt   = err_cnt_q;

    // Output stage: last-popped word, word address and drop bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            err_p1    <= 1'b0;
            err_cnt_q <= '0;
            addr_q    <= '0;
        end else begin
            if (pop) hold_q <= head_word;
            err_p1 <= drop;
            if (drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            if (bus.addr_load)
                addr_q <= bus.addr_base;
            else if (pop)
                addr_q <= addr_q + ADDR_W'(1);
        end
    end

endmodule
